// File: rtl/maze_pkg.sv
// Shared definitions for the maze player datapath: direction encodings,
// default grid geometry, datapath widths and the move sequencer state set.
package maze_pkg;

    // One-hot direction requests; bit index doubles as the direction index.
    localparam logic [3:0] DIR_XP = 4'b0001;
    localparam logic [3:0] DIR_YP = 4'b0010;
    localparam logic [3:0] DIR_YM = 4'b0100;
    localparam logic [3:0] DIR_XM = 4'b1000;

    localparam int DEF_GRID_W = 48;
    localparam int DEF_GRID_H = 48;
    localparam int ADDR_W     = 12;
    localparam int POS_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAW  = 3'd3,
        ST_WON   = 3'd4
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running movement-tick divider: counts 0..TICK_DIV-1 and raises tick
// for exactly the cycle the count sits at TICK_DIV-1.
module tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign tick = (count_reg == CNT_W'(TICK_DIV - 1));

    // Wrap to zero on the tick cycle, otherwise count up.
    always_comb begin
        count_next = tick ? '0 : count_reg + CNT_W'(1);
    end

    // Counter register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Game-step controller: on each movement tick it validates a one-hot move,
// looks up the target cell in the wall RAM, commits the move when the cell
// is open, hands a redraw request to the renderer and latches a win when the
// goal cell is reached.
module move_sequencer
    import maze_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int START_X  = 1,
    parameter int START_Y  = 2,
    parameter int GOAL_X   = 46,
    parameter int GOAL_Y   = 45,
    parameter int RAM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  mov,
    output logic        rd_en,
    output logic [11:0] rd_addr,
    input  logic        rd_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [9:0]  x_prev,
    output logic [9:0]  y_prev,
    output logic        draw_req,
    input  logic        draw_ack,
    output logic        busy,
    output logic        win
);

    // RAM_LAT is limited to 1..3, so a 2-bit wait counter is enough.
    localparam int WAIT_W = 2;

    logic tick;

    state_t state_reg;
    state_t state_next;

    logic [POS_W-1:0]  x_pos_reg,  x_pos_next;
    logic [POS_W-1:0]  y_pos_reg,  y_pos_next;
    logic [POS_W-1:0]  x_prev_reg, x_prev_next;
    logic [POS_W-1:0]  y_prev_reg, y_prev_next;
    logic [POS_W-1:0]  cand_x_reg, cand_x_next;
    logic [POS_W-1:0]  cand_y_reg, cand_y_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              rd_en_reg, rd_en_next;
    logic              draw_req_reg, draw_req_next;
    logic              win_reg, win_next;

    // Per-direction candidate cell and legality, indexed like the mov bits.
    logic [3:0]       dir_ok;
    logic [POS_W-1:0] dir_x [4];
    logic [POS_W-1:0] dir_y [4];

    logic [POS_W-1:0]  cand_x;
    logic [POS_W-1:0]  cand_y;
    logic [ADDR_W-1:0] cand_addr;
    logic              sel_ok;
    logic              mov_onehot;
    logic              move_ok;
    logic              at_goal;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Decrementing directions are guarded by a zero test so the candidate
    // never wraps; incrementing directions check the grid edge in 32 bits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir
            if (gi == 0) begin : g_xp
                assign dir_x[gi]  = x_pos_reg + 10'd1;
                assign dir_y[gi]  = y_pos_reg;
                assign dir_ok[gi] = (32'(x_pos_reg) + 32'd2) <= 32'(GRID_W);
            end else if (gi == 1) begin : g_yp
                assign dir_x[gi]  = x_pos_reg;
                assign dir_y[gi]  = y_pos_reg + 10'd1;
                assign dir_ok[gi] = (32'(y_pos_reg) + 32'd2) <= 32'(GRID_H);
            end else if (gi == 2) begin : g_ym
                assign dir_x[gi]  = x_pos_reg;
                assign dir_y[gi]  = (y_pos_reg != '0) ? y_pos_reg - 10'd1 : y_pos_reg;
                assign dir_ok[gi] = (y_pos_reg != '0);
            end else begin : g_xm
                assign dir_x[gi]  = (x_pos_reg != '0) ? x_pos_reg - 10'd1 : x_pos_reg;
                assign dir_y[gi]  = y_pos_reg;
                assign dir_ok[gi] = (x_pos_reg != '0);
            end
        end
    endgenerate

    // Pick the candidate for the requested direction; one-hot gating below
    // guarantees only a single bit contributes when the move is accepted.
    always_comb begin
        cand_x = x_pos_reg;
        cand_y = y_pos_reg;
        sel_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mov[i]) begin
                cand_x = dir_x[i];
                cand_y = dir_y[i];
                sel_ok = dir_ok[i];
            end
        end
    end

    assign mov_onehot = (mov != 4'd0) && ((mov & (mov - 4'd1)) == 4'd0);
    assign move_ok    = tick && en && mov_onehot && sel_ok;
    assign cand_addr  = ADDR_W'(cand_y) * ADDR_W'(GRID_W) + ADDR_W'(cand_x);
    assign at_goal    = (x_pos_reg == POS_W'(GOAL_X)) && (y_pos_reg == POS_W'(GOAL_Y));

    // State register; reset drops any in-flight move immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for one move: read, wait out RAM latency, decide, draw.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (move_ok) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_W'(RAM_LAT - 1)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = rd_data ? ST_IDLE : ST_DRAW;
            end
            ST_DRAW: begin
                if (draw_ack) begin
                    state_next = at_goal ? ST_WON : ST_IDLE;
                end
            end
            ST_WON: begin
                state_next = ST_WON;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: every register holds unless its state acts.
    always_comb begin
        x_pos_next    = x_pos_reg;
        y_pos_next    = y_pos_reg;
        x_prev_next   = x_prev_reg;
        y_prev_next   = y_prev_reg;
        cand_x_next   = cand_x_reg;
        cand_y_next   = cand_y_reg;
        rd_addr_next  = rd_addr_reg;
        wait_cnt_next = '0;
        rd_en_next    = 1'b0;
        draw_req_next = draw_req_reg;
        win_next      = win_reg;
        case (state_reg)
            ST_IDLE: begin
                if (move_ok) begin
                    rd_en_next   = 1'b1;
                    rd_addr_next = cand_addr;
                    cand_x_next  = cand_x;
                    cand_y_next  = cand_y;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
            ST_CHECK: begin
                if (!rd_data) begin
                    x_prev_next   = x_pos_reg;
                    y_prev_next   = y_pos_reg;
                    x_pos_next    = cand_x_reg;
                    y_pos_next    = cand_y_reg;
                    draw_req_next = 1'b1;
                end
            end
            ST_DRAW: begin
                if (draw_ack) begin
                    draw_req_next = 1'b0;
                    if (at_goal) begin
                        win_next = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers with asynchronous return to the start cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pos_reg    <= POS_W'(START_X);
            y_pos_reg    <= POS_W'(START_Y);
            x_prev_reg   <= POS_W'(START_X);
            y_prev_reg   <= POS_W'(START_Y);
            cand_x_reg   <= POS_W'(START_X);
            cand_y_reg   <= POS_W'(START_Y);
            rd_addr_reg  <= '0;
            wait_cnt_reg <= '0;
            rd_en_reg    <= 1'b0;
            draw_req_reg <= 1'b0;
            win_reg      <= 1'b0;
        end else begin
            x_pos_reg    <= x_pos_next;
            y_pos_reg    <= y_pos_next;
            x_prev_reg   <= x_prev_next;
            y_prev_reg   <= y_prev_next;
            cand_x_reg   <= cand_x_next;
            cand_y_reg   <= cand_y_next;
            rd_addr_reg  <= rd_addr_next;
            wait_cnt_reg <= wait_cnt_next;
            rd_en_reg    <= rd_en_next;
            draw_req_reg <= draw_req_next;
            win_reg      <= win_next;
        end
    end

    assign rd_en    = rd_en_reg;
    assign rd_addr  = rd_addr_reg;
    assign x_pos    = x_pos_reg;
    assign y_pos    = y_pos_reg;
    assign x_prev   = x_prev_reg;
    assign y_prev   = y_prev_reg;
    assign draw_req = draw_req_reg;
    assign win      = win_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a fast tick (TICK_DIV=4) and
// single-cycle RAM latency. A small position model predicts every move; the
// expected read address and target cell are queued when a move is requested
// and popped when the read strobe appears.
module tb_move_sequencer;
    import maze_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int RAM_LAT  = 1;
    localparam int GW = 48;
    localparam int GH = 48;
    localparam int SX = 1;
    localparam int SY = 2;
    localparam int GX = 46;
    localparam int GY = 45;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  mov;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        rd_data;
    logic [9:0]  x_pos, y_pos, x_prev, y_prev;
    logic        draw_req;
    logic        draw_ack;
    logic        busy;
    logic        win;

    int errors = 0;
    int checks = 0;

    // Reference model of the player state.
    int mx, my, mpx, mpy;
    bit mwin;

    typedef struct {
        int addr;
        int nx;
        int ny;
    } exp_t;
    exp_t sb[$];

    move_sequencer #(
        .TICK_DIV (TICK_DIV),
        .GRID_W   (GW),
        .GRID_H   (GH),
        .START_X  (SX),
        .START_Y  (SY),
        .GOAL_X   (GX),
        .GOAL_Y   (GY),
        .RAM_LAT  (RAM_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mov      (mov),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .x_prev   (x_prev),
        .y_prev   (y_prev),
        .draw_req (draw_req),
        .draw_ack (draw_ack),
        .busy     (busy),
        .win      (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"},     32'(x_pos),  mx);
        check({tag, "_y"},     32'(y_pos),  my);
        check({tag, "_xprev"}, 32'(x_prev), mpx);
        check({tag, "_yprev"}, 32'(y_prev), mpy);
        check({tag, "_win"},   32'(win),    32'(mwin));
    endtask

    task automatic model_reset();
        mx = SX; my = SY; mpx = SX; mpy = SY; mwin = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; mov = 4'd0; rd_data = 1'b0; draw_ack = 1'b0;
        model_reset();
        #1;
        check({tag, "_rd_en"},    32'(rd_en),    0);
        check({tag, "_rd_addr"},  32'(rd_addr),  0);
        check({tag, "_draw_req"}, 32'(draw_req), 0);
        check({tag, "_busy"},     32'(busy),     0);
        check_pos(tag);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("reset %s done", tag);
    endtask

    // One move attempt. ack_delay = 0 means draw_ack is already high when
    // DRAW is entered; otherwise draw_req must be seen for ack_delay cycles.
    task automatic move(input logic [3:0] m, input bit wall, input int ack_delay, input string tag);
        int   dx, dy, nx, ny, seen;
        bit   legal;
        exp_t e;
        dx = 0; dy = 0; legal = !mwin;
        case (m)
            DIR_XP:  dx = 1;
            DIR_YP:  dy = 1;
            DIR_YM:  dy = -1;
            DIR_XM:  dx = -1;
            default: legal = 1'b0;
        endcase
        nx = mx + dx;
        ny = my + dy;
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) legal = 1'b0;

        mov = m; en = 1'b1; rd_data = !wall; draw_ack = 1'b0;

        if (!legal) begin
            seen = 0;
            repeat (3 * TICK_DIV) begin
                @(negedge clk);
                if (rd_en) seen++;
            end
            en = 1'b0;
            check({tag, "_no_rd"}, seen, 0);
            check({tag, "_busy"}, 32'(busy), 32'(mwin));
            check_pos(tag);
            $display("move %s mov=%b rejected pos=(%0d,%0d)", tag, m, x_pos, y_pos);
            return;
        end

        e.addr = ny * GW + nx; e.nx = nx; e.ny = ny;
        sb.push_back(e);

        seen = 0;
        for (int i = 0; i < 4 * TICK_DIV; i++) begin
            @(negedge clk);
            if (rd_en) begin
                seen = 1;
                break;
            end
        end
        en = 1'b0;
        e = sb.pop_front();
        check({tag, "_rd_seen"}, seen, 1);
        if (seen == 0) return;
        check({tag, "_rd_addr"}, 32'(rd_addr), e.addr);

        // Data must be sampled exactly RAM_LAT cycles after the strobe.
        @(negedge clk);
        rd_data = wall;
        if (!wall && ack_delay == 0) draw_ack = 1'b1;
        check({tag, "_rd_pulse"}, 32'(rd_en), 0);
        check({tag, "_busy_mid"}, 32'(busy), 1);

        @(negedge clk);
        rd_data = !wall;
        if (wall) begin
            check({tag, "_draw_req"}, 32'(draw_req), 0);
            check({tag, "_busy_end"}, 32'(busy), 0);
            check_pos(tag);
            $display("move %s mov=%b addr=%0d wall pos=(%0d,%0d)", tag, m, rd_addr, x_pos, y_pos);
            return;
        end

        mpx = mx; mpy = my; mx = e.nx; my = e.ny;
        check({tag, "_draw_req_h0"}, 32'(draw_req), 1);
        for (int i = 1; i < ack_delay; i++) begin
            @(negedge clk);
            check({tag, "_draw_req_h"}, 32'(draw_req), 1);
        end
        draw_ack = 1'b1;
        @(negedge clk);
        draw_ack = 1'b0;
        check({tag, "_draw_req_l"}, 32'(draw_req), 0);
        if (mx == GX && my == GY) mwin = 1'b1;
        check({tag, "_busy_end"}, 32'(busy), 32'(mwin));
        check_pos(tag);
        $display("move %s mov=%b addr=%0d pos=(%0d,%0d) prev=(%0d,%0d) win=%0d",
                 tag, m, rd_addr, x_pos, y_pos, x_prev, y_prev, win);
    endtask

    initial begin
        int seen;
        rst = 1'b1; en = 1'b0; mov = 4'd0; rd_data = 1'b0; draw_ack = 1'b0;
        model_reset();

        do_reset("init");

        // Open cell to the right, acknowledge two cycles after the request.
        move(DIR_XP, 1'b0, 2, "first");

        // Wall below the start cell.
        do_reset("pre_wall");
        move(DIR_YP, 1'b1, 1, "wall");

        // Left edge and malformed direction requests.
        move(DIR_XM, 1'b0, 1, "to_x0");
        move(DIR_XM, 1'b0, 1, "xm_edge");
        move(4'b0011, 1'b0, 1, "multi_hot");
        move(4'b0000, 1'b0, 1, "no_dir");

        // Enable low across several ticks: nothing may start.
        mov = DIR_XP; en = 1'b0; seen = 0;
        repeat (3 * TICK_DIV) begin
            @(negedge clk);
            if (rd_en) seen++;
        end
        check("en_low_no_rd", seen, 0);
        check_pos("en_low");
        $display("move en_low rd_en_pulses=%0d", seen);

        // Acknowledge already high on entry to DRAW.
        move(DIR_XP, 1'b0, 0, "ack_early");

        // Walk to the bottom edge and try to leave the grid.
        for (int i = 0; i < 45; i++) move(DIR_YP, 1'b0, 1, "walk_y");
        move(DIR_YP, 1'b0, 1, "yp_edge");

        // Head for the goal.
        move(DIR_YM, 1'b0, 1, "walk_up");
        move(DIR_YM, 1'b0, 1, "walk_up");
        for (int i = 0; i < 44; i++) move(DIR_XP, 1'b0, 1, "walk_x");
        move(DIR_XP, 1'b0, 2, "goal");

        // Play is frozen after the win.
        move(DIR_XM, 1'b0, 1, "frozen_xm");
        move(DIR_YP, 1'b0, 1, "frozen_yp");

        // Reset clears the win.
        do_reset("after_win");

        // Asynchronous reset while a redraw is pending.
        mov = DIR_XP; en = 1'b1; rd_data = 1'b0; draw_ack = 1'b0; seen = 0;
        for (int i = 0; i < 6 * TICK_DIV; i++) begin
            @(negedge clk);
            if (rd_en) en = 1'b0;
            if (draw_req) begin
                seen = 1;
                break;
            end
        end
        en = 1'b0;
        check("middraw_reached", seen, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("middraw_draw_req", 32'(draw_req), 0);
        check("middraw_busy",     32'(busy),     0);
        check("middraw_rd_en",    32'(rd_en),    0);
        check_pos("middraw");
        $display("async reset mid-draw pos=(%0d,%0d) draw_req=%0d", x_pos, y_pos, draw_req);
        @(negedge clk);
        rst = 1'b0;

        move(DIR_XP, 1'b0, 1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
